// File: rtl/hazard_dest_pipe_if.sv
// ID-stage decode inputs and pipelined destination/control outputs of the
// destination-tracking pipe.
interface hazard_dest_pipe_if #(
    parameter int unsigned REG_W = 5,
    parameter int unsigned CNT_W = 16
);
    logic             ID_RegWrite;
    logic             ID_MemRead;
    logic [REG_W-1:0] ID_Rd;
    logic [REG_W-1:0] ID_Rs;
    logic [REG_W-1:0] ID_Rt;
    logic             Flush;

    logic             IDEX_RegWrite;
    logic             IDEX_MemRead;
    logic [REG_W-1:0] IDEX_Rd;
    logic [REG_W-1:0] IDEX_Rs;
    logic [REG_W-1:0] IDEX_Rt;
    logic             EXMEM_RegWrite;
    logic [REG_W-1:0] EXMEM_Rd;
    logic             MEMWB_RegWrite;
    logic [REG_W-1:0] MEMWB_Rd;
    logic             Stall;
    logic [CNT_W-1:0] StallCount;

    modport master (
        output ID_RegWrite, ID_MemRead, ID_Rd, ID_Rs, ID_Rt, Flush,
        input  IDEX_RegWrite, IDEX_MemRead, IDEX_Rd, IDEX_Rs, IDEX_Rt,
        input  EXMEM_RegWrite, EXMEM_Rd, MEMWB_RegWrite, MEMWB_Rd,
        input  Stall, StallCount
    );

    modport slave (
        input  ID_RegWrite, ID_MemRead, ID_Rd, ID_Rs, ID_Rt, Flush,
        output IDEX_RegWrite, IDEX_MemRead, IDEX_Rd, IDEX_Rs, IDEX_Rt,
        output EXMEM_RegWrite, EXMEM_Rd, MEMWB_RegWrite, MEMWB_Rd,
        output Stall, StallCount
    );
endinterface

// File: rtl/hazard_dest_pipe.sv
// Destination/control shift pipeline (ID/EX, EX/MEM, MEM/WB) with load-use
// stall detection, bubble insertion and a saturating stall counter.
module hazard_dest_pipe #(
    parameter int unsigned REG_W = 5,
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    hazard_dest_pipe_if.slave bus
);
    typedef struct packed {
        logic             reg_write;
        logic             mem_read;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
    } idex_t;

    typedef struct packed {
        logic             reg_write;
        logic [REG_W-1:0] rd;
    } wb_t;

    idex_t            idex_q;
    idex_t            idex_d;
    wb_t              exmem_q;
    wb_t              memwb_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic             load_use;
    logic             stall;

    // Flush wins over stall: the dependent instruction is being squashed anyway.
    always_comb begin
        load_use = idex_q.mem_read && (idex_q.rd != '0) &&
                   ((idex_q.rd == bus.ID_Rs) || (idex_q.rd == bus.ID_Rt));
        stall    = load_use && !bus.Flush;
    end

    // ID/EX capture: bubble on stall/flush, writes to register 0 are dropped.
    always_comb begin
        idex_d = '0;
        if (!(stall || bus.Flush)) begin
            idex_d.reg_write = bus.ID_RegWrite && (bus.ID_Rd != '0);
            idex_d.mem_read  = bus.ID_MemRead;
            idex_d.rd        = bus.ID_Rd;
            idex_d.rs        = bus.ID_Rs;
            idex_d.rt        = bus.ID_Rt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idex_q      <= '0;
            exmem_q     <= '0;
            memwb_q     <= '0;
            stall_cnt_q <= '0;
        end else begin
            idex_q            <= idex_d;
            exmem_q.reg_write <= idex_q.reg_write;
            exmem_q.rd        <= idex_q.rd;
            memwb_q           <= exmem_q;
            if (stall && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.IDEX_RegWrite  = idex_q.reg_write;
    assign bus.IDEX_MemRead   = idex_q.mem_read;
    assign bus.IDEX_Rd        = idex_q.rd;
    assign bus.IDEX_Rs        = idex_q.rs;
    assign bus.IDEX_Rt        = idex_q.rt;
    assign bus.EXMEM_RegWrite = exmem_q.reg_write;
    assign bus.EXMEM_Rd       = exmem_q.rd;
    assign bus.MEMWB_RegWrite = memwb_q.reg_write;
    assign bus.MEMWB_Rd       = memwb_q.rd;
    assign bus.Stall          = stall;
    assign bus.StallCount     = stall_cnt_q;
endmodule

// File: tb/tb_hazard_dest_pipe.sv
// Directed self-checking bench for hazard_dest_pipe (4-bit stall counter so
// saturation is reachable quickly).
module tb_hazard_dest_pipe;
    localparam int unsigned RW    = 5;
    localparam int unsigned CW    = 4;
    localparam int unsigned ALL_W = 3 * RW + 2 + 2 * (RW + 1);

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   exp_cnt;

    hazard_dest_pipe_if #(.REG_W(RW), .CNT_W(CW)) bus ();

    hazard_dest_pipe #(.REG_W(RW), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [ALL_W-1:0]  all_regs;
    logic [3*RW+1:0]   idex_vec;
    assign all_regs = {bus.IDEX_RegWrite, bus.IDEX_MemRead, bus.IDEX_Rd, bus.IDEX_Rs, bus.IDEX_Rt,
                       bus.EXMEM_RegWrite, bus.EXMEM_Rd, bus.MEMWB_RegWrite, bus.MEMWB_Rd};
    assign idex_vec = {bus.IDEX_RegWrite, bus.IDEX_MemRead, bus.IDEX_Rd, bus.IDEX_Rs, bus.IDEX_Rt};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic rw, input logic mr, input int rd, input int rs,
                         input int rt, input logic fl);
        bus.ID_RegWrite = rw;
        bus.ID_MemRead  = mr;
        bus.ID_Rd       = RW'(rd);
        bus.ID_Rs       = RW'(rs);
        bus.ID_Rt       = RW'(rt);
        bus.Flush       = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_state();
        checks++; if (all_regs !== '0) begin errors++; $display("FAIL reset_regs: got %h exp 0", all_regs); end
        checks++; if (bus.Stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b exp 0", bus.Stall); end
        checks++; if (bus.StallCount !== 4'd0) begin errors++; $display("FAIL reset_cnt: got %0d exp 0", bus.StallCount); end
    endtask

    task automatic test_shift();
        drive(1, 0, 5, 0, 0, 0); tick();
        checks++; if (bus.IDEX_Rd !== 5'd5) begin errors++; $display("FAIL shift_idex5: got %0d exp 5", bus.IDEX_Rd); end
        drive(1, 0, 6, 0, 0, 0); tick();
        checks++; if (bus.EXMEM_Rd !== 5'd5) begin errors++; $display("FAIL shift_exmem5: got %0d exp 5", bus.EXMEM_Rd); end
        checks++; if (bus.IDEX_Rd !== 5'd6) begin errors++; $display("FAIL shift_idex6: got %0d exp 6", bus.IDEX_Rd); end
        drive(1, 0, 7, 0, 0, 0); tick();
        checks++; if (bus.EXMEM_Rd !== 5'd6) begin errors++; $display("FAIL shift_exmem6: got %0d exp 6", bus.EXMEM_Rd); end
        checks++; if (bus.MEMWB_Rd !== 5'd5) begin errors++; $display("FAIL shift_memwb5: got %0d exp 5", bus.MEMWB_Rd); end
        checks++; if (bus.Stall !== 1'b0) begin errors++; $display("FAIL shift_stall: got %b exp 0", bus.Stall); end
        drive(0, 0, 0, 0, 0, 0); tick();
        checks++; if (bus.EXMEM_Rd !== 5'd7) begin errors++; $display("FAIL shift_exmem7: got %0d exp 7", bus.EXMEM_Rd); end
        checks++; if (bus.EXMEM_RegWrite !== 1'b1) begin errors++; $display("FAIL shift_exmem_rw: got %b exp 1", bus.EXMEM_RegWrite); end
        checks++; if (bus.MEMWB_Rd !== 5'd6) begin errors++; $display("FAIL shift_memwb6: got %0d exp 6", bus.MEMWB_Rd); end
        tick();
        checks++; if (bus.MEMWB_Rd !== 5'd7) begin errors++; $display("FAIL shift_memwb7: got %0d exp 7", bus.MEMWB_Rd); end
    endtask

    task automatic test_load_use();
        drive(1, 1, 8, 1, 2, 0); tick();
        drive(1, 0, 9, 8, 3, 0); #1;
        checks++; if (bus.Stall !== 1'b1) begin errors++; $display("FAIL lu_stall: got %b exp 1", bus.Stall); end
        tick(); exp_cnt++;
        checks++; if (idex_vec !== '0) begin errors++; $display("FAIL lu_bubble: got %h exp 0", idex_vec); end
        checks++; if (bus.Stall !== 1'b0) begin errors++; $display("FAIL lu_stall_drop: got %b exp 0", bus.Stall); end
        checks++; if (bus.EXMEM_Rd !== 5'd8) begin errors++; $display("FAIL lu_exmem: got %0d exp 8", bus.EXMEM_Rd); end
        checks++; if (bus.StallCount !== CW'(exp_cnt)) begin errors++; $display("FAIL lu_cnt: got %0d exp %0d", bus.StallCount, exp_cnt); end
        tick();
        checks++; if (bus.IDEX_Rd !== 5'd9 || bus.IDEX_Rs !== 5'd8) begin errors++; $display("FAIL lu_dep: got rd %0d rs %0d exp 9 8", bus.IDEX_Rd, bus.IDEX_Rs); end
        checks++; if (bus.MEMWB_Rd !== 5'd8 || bus.MEMWB_RegWrite !== 1'b1) begin errors++; $display("FAIL lu_memwb: got %0d/%b exp 8/1", bus.MEMWB_Rd, bus.MEMWB_RegWrite); end
        drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_zero_reg();
        drive(1, 1, 0, 0, 0, 0); tick();
        checks++; if (bus.IDEX_RegWrite !== 1'b0 || bus.IDEX_MemRead !== 1'b1) begin errors++; $display("FAIL zr_norm: got rw %b mr %b exp 0 1", bus.IDEX_RegWrite, bus.IDEX_MemRead); end
        drive(1, 0, 4, 1, 0, 0); #1;
        checks++; if (bus.Stall !== 1'b0) begin errors++; $display("FAIL zr_stall: got %b exp 0", bus.Stall); end
        tick();
        checks++; if (bus.IDEX_Rd !== 5'd4) begin errors++; $display("FAIL zr_enter: got %0d exp 4", bus.IDEX_Rd); end
        checks++; if (bus.StallCount !== CW'(exp_cnt)) begin errors++; $display("FAIL zr_cnt: got %0d exp %0d", bus.StallCount, exp_cnt); end
        // A dependency through a non-load must not stall.
        drive(1, 0, 7, 0, 0, 0); tick();
        drive(1, 0, 2, 7, 7, 0); #1;
        checks++; if (bus.Stall !== 1'b0) begin errors++; $display("FAIL noload_stall: got %b exp 0", bus.Stall); end
        tick();
        drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_flush();
        drive(1, 1, 3, 0, 0, 0); tick();
        drive(1, 0, 6, 1, 3, 1); #1;
        checks++; if (bus.Stall !== 1'b0) begin errors++; $display("FAIL fl_stall: got %b exp 0", bus.Stall); end
        tick();
        checks++; if (idex_vec !== '0) begin errors++; $display("FAIL fl_bubble: got %h exp 0", idex_vec); end
        checks++; if (bus.EXMEM_Rd !== 5'd3) begin errors++; $display("FAIL fl_exmem: got %0d exp 3", bus.EXMEM_Rd); end
        checks++; if (bus.StallCount !== CW'(exp_cnt)) begin errors++; $display("FAIL fl_cnt: got %0d exp %0d", bus.StallCount, exp_cnt); end
        drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        drive(1, 1, 4, 0, 0, 0); tick();
        drive(1, 1, 5, 4, 0, 0); #1;
        checks++; if (bus.Stall !== 1'b1) begin errors++; $display("FAIL b2b_stall1: got %b exp 1", bus.Stall); end
        tick(); exp_cnt++;
        checks++; if (bus.Stall !== 1'b0 || idex_vec !== '0) begin errors++; $display("FAIL b2b_bubble1: got stall %b idex %h exp 0 0", bus.Stall, idex_vec); end
        tick();
        checks++; if (bus.IDEX_Rd !== 5'd5 || bus.IDEX_MemRead !== 1'b1) begin errors++; $display("FAIL b2b_load2: got rd %0d mr %b exp 5 1", bus.IDEX_Rd, bus.IDEX_MemRead); end
        drive(1, 0, 6, 5, 0, 0); #1;
        checks++; if (bus.Stall !== 1'b1) begin errors++; $display("FAIL b2b_stall2: got %b exp 1", bus.Stall); end
        tick(); exp_cnt++;
        checks++; if (idex_vec !== '0) begin errors++; $display("FAIL b2b_bubble2: got %h exp 0", idex_vec); end
        tick();
        checks++; if (bus.IDEX_Rd !== 5'd6) begin errors++; $display("FAIL b2b_dep: got %0d exp 6", bus.IDEX_Rd); end
        checks++; if (bus.StallCount !== CW'(exp_cnt)) begin errors++; $display("FAIL b2b_cnt: got %0d exp %0d", bus.StallCount, exp_cnt); end
        drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset_mid_stall();
        drive(1, 1, 10, 0, 0, 0); tick();
        drive(1, 0, 11, 10, 0, 0); #1;
        checks++; if (bus.Stall !== 1'b1 || all_regs === '0) begin errors++; $display("FAIL rst_pre: got stall %b regs %h exp 1 nonzero", bus.Stall, all_regs); end
        reset = 1'b1; #1;
        exp_cnt = 0;
        checks++; if (all_regs !== '0) begin errors++; $display("FAIL rst_regs: got %h exp 0", all_regs); end
        checks++; if (bus.Stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b exp 0", bus.Stall); end
        checks++; if (bus.StallCount !== 4'd0) begin errors++; $display("FAIL rst_cnt: got %0d exp 0", bus.StallCount); end
        drive(0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        tick();
        checks++; if (all_regs !== '0 || bus.StallCount !== 4'd0) begin errors++; $display("FAIL rst_after: got %h/%0d exp 0/0", all_regs, bus.StallCount); end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 20; i++) begin
            drive(1, 1, 8, 0, 0, 0); tick();
            drive(1, 0, 9, 8, 0, 0); tick();
            tick();
            drive(0, 0, 0, 0, 0, 0);
            exp_cnt = (exp_cnt < 15) ? exp_cnt + 1 : 15;
            checks++; if (bus.StallCount !== CW'(exp_cnt)) begin errors++; $display("FAIL sat_cnt%0d: got %0d exp %0d", i, bus.StallCount, exp_cnt); end
        end
        checks++; if (bus.StallCount !== 4'd15) begin errors++; $display("FAIL sat_final: got %0d exp 15", bus.StallCount); end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        exp_cnt = 0;
        reset   = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        #12;
        test_reset_state();
        reset = 1'b0;
        test_shift();
        test_load_use();
        test_zero_reg();
        test_flush();
        test_back_to_back();
        test_reset_mid_stall();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
